// File: rtl/morse_player_if.sv
// Character-entry / buzzer side signals of the Morse playback stage.
interface morse_player_if;
  logic       push;
  logic [4:0] char_code;
  logic [2:0] char_len;
  logic       start;
  logic       abort;
  logic [1:0] speed;
  logic       beep;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  modport master (
    output push, char_code, char_len, start, abort, speed,
    input  beep, busy, done, count, full, empty, overflow
  );

  modport slave (
    input  push, char_code, char_len, start, abort, speed,
    output beep, busy, done, count, full, empty, overflow
  );
endinterface

// File: rtl/morse_player.sv
// Morse playback stage: 8-entry character FIFO feeding a dot/dash/gap
// sequencer that drives a square-wave buzzer tone.
module morse_player #(
  parameter int DEPTH     = 8,
  parameter int UNIT_BASE = 10_000_000,
  parameter int TONE_DIV  = 50_000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  morse_player_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [31:0] DIV_LAST = 32'(TONE_DIV - 1);
  localparam logic [31:0] UNIT0    = 32'(UNIT_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_TONE, S_ELEM_GAP, S_CHAR_GAP, S_WORD_GAP, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [4:0]    r_code;
  logic [2:0]    r_len, r_idx;
  logic [31:0]   r_unit, r_cnt, r_limit, r_div;
  logic          r_tone;

  logic [7:0]  w_head;
  logic [2:0]  w_hlen;
  logic        w_full, w_empty, w_pop, w_wr, w_end, w_last, w_dash_next;
  logic [31:0] w_unit_fetch, w_unit, w_limit_next;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_hlen       = (w_head[7:5] > 3'd5) ? 3'd5 : w_head[7:5];
  assign w_full       = (r_count == FULL_CNT);
  assign w_empty      = (r_count == '0);
  assign w_pop        = (r_state == S_FETCH) && !bus.abort;
  // A push while full is only accepted when the fetch frees a slot this cycle.
  assign w_wr         = bus.push && !bus.abort && (!w_full || w_pop);
  assign w_end        = (r_cnt == r_limit - 32'd1);
  assign w_last       = (r_idx == r_len - 3'd1);
  assign w_unit_fetch = UNIT0 << bus.speed;

  assign bus.beep     = (r_state == S_TONE) && r_tone;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.count    = 4'(r_count);
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.overflow = r_overflow;

  // FIFO storage write port (contents are don't-care until written).
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {bus.char_len, bus.char_code};
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.abort) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      if (bus.push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.start && !w_empty) w_next = S_FETCH;
      S_FETCH:    w_next = (w_hlen == 3'd0) ? S_WORD_GAP : S_TONE;
      S_TONE:     if (w_end) begin
                    if (w_last) w_next = w_empty ? S_DONE : S_CHAR_GAP;
                    else        w_next = S_ELEM_GAP;
                  end
      S_ELEM_GAP: if (w_end) w_next = S_TONE;
      S_CHAR_GAP: if (w_end) w_next = S_FETCH;
      S_WORD_GAP: if (w_end) w_next = w_empty ? S_DONE : S_FETCH;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end

  // Length in cycles of the phase being entered; during FETCH the new unit
  // and first element come straight from the FIFO head.
  always_comb begin
    w_unit       = (r_state == S_FETCH) ? w_unit_fetch : r_unit;
    w_dash_next  = (r_state == S_FETCH) ? w_head[0] : r_code[r_idx];
    w_limit_next = w_unit;
    case (w_next)
      S_TONE:     w_limit_next = w_dash_next ? (w_unit << 1) + w_unit : w_unit;
      S_CHAR_GAP: w_limit_next = (w_unit << 1) + w_unit;
      S_WORD_GAP: w_limit_next = (w_unit << 3) - w_unit;
      default:    w_limit_next = w_unit;
    endcase
  end

  // Phase timer, latched character, element index and tone divider.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_limit <= '0;
      r_unit  <= '0;
      r_code  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_div   <= '0;
      r_tone  <= 1'b0;
    end else if (bus.abort) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_div   <= '0;
      r_tone  <= 1'b0;
    end else begin
      if ((w_next != r_state) || (r_state == S_IDLE)) begin
        r_cnt   <= '0;
        r_limit <= w_limit_next;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (r_state == S_FETCH) begin
        r_code <= w_head[4:0];
        r_len  <= w_hlen;
        r_unit <= w_unit_fetch;
        r_idx  <= '0;
      end else if ((r_state == S_TONE) && w_end && !w_last) begin
        r_idx <= r_idx + 3'd1;
      end
      // Divider restarts on entry so every element begins with beep high.
      if ((w_next == S_TONE) && (r_state != S_TONE)) begin
        r_tone <= 1'b1;
        r_div  <= '0;
      end else if (r_state == S_TONE) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_tone <= ~r_tone;
        end else begin
          r_div <= r_div + 32'd1;
        end
      end
    end
  end
endmodule
